// File: rtl/awgn_pkg.sv
// awgn_pkg: shared widths, scale constants and the output saturation helper
// for the AWGN channel model.
package awgn_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NOISE_W  = 16;
    localparam int DEF_SCALE_W  = 16;
    localparam int DEF_SATCNT_W = 16;

    // Q1.15 unity gain and the shift that brings the product back to symbol LSBs
    localparam logic [15:0] SCALE_ONE   = 16'h8000;
    localparam int          SCALE_SHIFT = 15;

    // Adder width: symbol plus 18-bit scaled noise, both sign-extended
    localparam int SAT_IN_W = DEF_DATA_W + 3;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] val;
        logic                  sat;
    } sat_res_t;

    // Clamp a (W+3)-bit signed value into W bits; flags when clamping happened.
    // The value fits when every bit from the W-bit sign position upward agrees.
    function automatic sat_res_t sat_w3(input logic [SAT_IN_W-1:0] x);
        sat_res_t r;
        r.sat = 1'b0;
        r.val = x[DEF_DATA_W-1:0];
        if (!(&x[SAT_IN_W-1:DEF_DATA_W-1]) && (|x[SAT_IN_W-1:DEF_DATA_W-1])) begin
            r.sat = 1'b1;
            r.val = x[SAT_IN_W-1] ? {1'b1, {(DEF_DATA_W-1){1'b0}}}
                                  : {1'b0, {(DEF_DATA_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/awgn_channel_if.sv
// awgn_channel_if: symbol, noise, scale, output and statistics signals of the
// AWGN channel. The 'slave' modport is the channel itself; 'master' is the
// side that feeds symbols/noise and consumes the noisy stream.
interface awgn_channel_if #(
    parameter int DATA_W   = 16,
    parameter int NOISE_W  = 16,
    parameter int SCALE_W  = 16,
    parameter int SATCNT_W = 16
);
    logic [NOISE_W-1:0]  noise_in;
    logic [DATA_W-1:0]   sym_in;
    logic                sym_valid;
    logic                sym_last;
    logic                sym_ready;
    logic [SCALE_W-1:0]  scale_in;
    logic                scale_wr;
    logic [DATA_W-1:0]   ch_out;
    logic                ch_valid;
    logic                ch_last;
    logic                ch_ready;
    logic [SATCNT_W-1:0] sat_count;
    logic                stats_clr;
    logic [31:0]         noise_sum;
    logic [47:0]         noise_sq_sum;
    logic [31:0]         stats_n;

    modport slave (
        input  noise_in, sym_in, sym_valid, sym_last, scale_in, scale_wr,
               ch_ready, stats_clr,
        output sym_ready, ch_out, ch_valid, ch_last, sat_count,
               noise_sum, noise_sq_sum, stats_n
    );

    modport master (
        output noise_in, sym_in, sym_valid, sym_last, scale_in, scale_wr,
               ch_ready, stats_clr,
        input  sym_ready, ch_out, ch_valid, ch_last, sat_count,
               noise_sum, noise_sq_sum, stats_n
    );
endinterface

// File: rtl/awgn_noise_scale.sv
// awgn_noise_scale: S2 of the channel pipeline. Registers
// (signed noise * unsigned Q1.15 scale) >>> 15 as an 18-bit signed value and
// carries the symbol, last flag and valid bit alongside it.
module awgn_noise_scale
    import awgn_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NOISE_W = DEF_NOISE_W,
    parameter int SCALE_W = DEF_SCALE_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load_en,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_sym,
    input  logic [NOISE_W-1:0] i_noise,
    input  logic [SCALE_W-1:0] i_scale,
    input  logic               i_last,
    output logic               o_valid,
    output logic [DATA_W-1:0]  o_sym,
    output logic [NOISE_W+1:0] o_scaled,
    output logic               o_last
);
    // Scale is zero-extended so the multiply stays signed without changing its value
    logic signed [NOISE_W+SCALE_W:0] w_prod;
    logic        [NOISE_W+1:0]       w_scaled;

    assign w_prod   = $signed(i_noise) * $signed({1'b0, i_scale});
    // Taking the upper bits of a signed product is an arithmetic shift (floor)
    assign w_scaled = w_prod[SCALE_SHIFT +: NOISE_W+2];

    // Stage register: loads when empty or when its contents move on
    always_ff @(posedge clock) begin
        if (reset) begin
            o_valid  <= 1'b0;
            o_sym    <= '0;
            o_scaled <= '0;
            o_last   <= 1'b0;
        end else if (i_load_en) begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_sym    <= i_sym;
                o_scaled <= w_scaled;
                o_last   <= i_last;
            end
        end
    end

endmodule

// File: rtl/awgn_channel.sv
// awgn_channel: adds scaled Gaussian noise to a signed symbol stream.
// 3-stage valid/ready pipeline (capture, scale, saturating add), frame-
// synchronous noise-scale update and a sticky saturation counter.
// Optional noise statistics accumulators are built when AWGN_STATS_EN is
// defined; otherwise the statistics outputs are tied to zero.
module awgn_channel
    import awgn_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NOISE_W  = DEF_NOISE_W,
    parameter int SCALE_W  = DEF_SCALE_W,
    parameter int SATCNT_W = DEF_SATCNT_W
) (
    input  logic           clock,
    input  logic           reset,
    awgn_channel_if.slave  bus
);
    // ---------------- pipeline control ----------------
    logic w_s1_load, w_s2_load, w_s3_load, w_accept;
    logic w_s2_valid;

    logic               r_s1_valid;
    logic [DATA_W-1:0]  r_s1_sym;
    logic [NOISE_W-1:0] r_s1_noise;
    logic [SCALE_W-1:0] r_s1_scale;
    logic               r_s1_last;

    logic [DATA_W-1:0]  w_s2_sym;
    logic [NOISE_W+1:0] w_s2_scaled;
    logic               w_s2_last;

    logic                r_s3_valid;
    logic [DATA_W-1:0]   r_s3_out;
    logic                r_s3_last;
    logic [SATCNT_W-1:0] r_sat_cnt;

    logic [SCALE_W-1:0] r_shadow_scale;
    logic [SCALE_W-1:0] r_active_scale;
    logic               r_scale_pending;

    // Each stage loads when empty or when its occupant leaves this cycle;
    // the ready chain is purely combinational back from ch_ready.
    assign w_s3_load = !r_s3_valid || bus.ch_ready;
    assign w_s2_load = !w_s2_valid || w_s3_load;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_accept  = bus.sym_valid && w_s1_load;

    assign bus.sym_ready = w_s1_load;

    // Scale shadow/active pair: active only changes on a frame-last accept
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow_scale  <= SCALE_W'(SCALE_ONE);
            r_active_scale  <= SCALE_W'(SCALE_ONE);
            r_scale_pending <= 1'b0;
        end else begin
            if (bus.scale_wr) begin
                r_shadow_scale  <= bus.scale_in;
                r_scale_pending <= 1'b1;
            end
            // A write landing in the same cycle as the last accept is forwarded
            if (w_accept && bus.sym_last && (r_scale_pending || bus.scale_wr)) begin
                r_active_scale  <= bus.scale_wr ? bus.scale_in : r_shadow_scale;
                r_scale_pending <= 1'b0;
            end
        end
    end

    // S1: capture symbol, the noise of the accept cycle and the scale in force
    // before any update triggered by this same accept
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sym   <= '0;
            r_s1_noise <= '0;
            r_s1_scale <= '0;
            r_s1_last  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.sym_valid;
            if (bus.sym_valid) begin
                r_s1_sym   <= bus.sym_in;
                r_s1_noise <= bus.noise_in;
                r_s1_scale <= r_active_scale;
                r_s1_last  <= bus.sym_last;
            end
        end
    end

    // ---------------- S2: multiply / shift ----------------
    awgn_noise_scale #(
        .DATA_W  (DATA_W),
        .NOISE_W (NOISE_W),
        .SCALE_W (SCALE_W)
    ) u_noise_scale (
        .clock     (clock),
        .reset     (reset),
        .i_load_en (w_s2_load),
        .i_valid   (r_s1_valid),
        .i_sym     (r_s1_sym),
        .i_noise   (r_s1_noise),
        .i_scale   (r_s1_scale),
        .i_last    (r_s1_last),
        .o_valid   (w_s2_valid),
        .o_sym     (w_s2_sym),
        .o_scaled  (w_s2_scaled),
        .o_last    (w_s2_last)
    );

    // ---------------- S3: saturating add ----------------
    logic [DATA_W+2:0] w_sum;
    sat_res_t          w_sat;

    assign w_sum = {{3{w_s2_sym[DATA_W-1]}}, w_s2_sym}
                 + {{(DATA_W+1-NOISE_W){w_s2_scaled[NOISE_W+1]}}, w_s2_scaled};
    assign w_sat = sat_w3(w_sum);

    // S3 output register and sticky saturation counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s3_valid <= 1'b0;
            r_s3_out   <= '0;
            r_s3_last  <= 1'b0;
            r_sat_cnt  <= '0;
        end else if (w_s3_load) begin
            r_s3_valid <= w_s2_valid;
            if (w_s2_valid) begin
                r_s3_out  <= w_sat.val;
                r_s3_last <= w_s2_last;
                if (w_sat.sat && (r_sat_cnt != '1))
                    r_sat_cnt <= r_sat_cnt + 1'b1;
            end
        end
    end

    assign bus.ch_out    = r_s3_out;
    assign bus.ch_valid  = r_s3_valid;
    assign bus.ch_last   = r_s3_last;
    assign bus.sat_count = r_sat_cnt;

    // ---------------- optional noise statistics ----------------
`ifdef AWGN_STATS_EN
    logic [31:0]               r_noise_sum;
    logic [47:0]               r_noise_sq_sum;
    logic [31:0]               r_stats_n;
    logic signed [2*NOISE_W+3:0] w_sq;

    assign w_sq = $signed(w_s2_scaled) * $signed(w_s2_scaled);

    // Accumulate on every S3 load of a valid sample; clear beats a load
    always_ff @(posedge clock) begin
        if (reset || bus.stats_clr) begin
            r_noise_sum    <= '0;
            r_noise_sq_sum <= '0;
            r_stats_n      <= '0;
        end else if (w_s3_load && w_s2_valid) begin
            r_noise_sum    <= r_noise_sum
                            + {{(32-NOISE_W-2){w_s2_scaled[NOISE_W+1]}}, w_s2_scaled};
            r_noise_sq_sum <= r_noise_sq_sum + {{(48-2*NOISE_W-4){1'b0}}, w_sq};
            r_stats_n      <= r_stats_n + 32'd1;
        end
    end

    assign bus.noise_sum    = r_noise_sum;
    assign bus.noise_sq_sum = r_noise_sq_sum;
    assign bus.stats_n      = r_stats_n;
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = bus.stats_clr;

    assign bus.noise_sum    = '0;
    assign bus.noise_sq_sum = '0;
    assign bus.stats_n      = '0;
`endif

endmodule

// File: tb/tb_awgn_channel.sv
// tb_awgn_channel: directed vectors with hand-computed expectations for
// awgn_channel (add, scaling, saturation, backpressure, reset, statistics).
module tb_awgn_channel;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clock = ~clock;

    awgn_channel_if bus ();

    awgn_channel u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] d;
        logic        l;
        int          c;
    } out_t;

    out_t out_q[$];
    int   acc_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Handshakes observed mid-cycle, away from the active edge
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.ch_valid && bus.ch_ready)
                out_q.push_back('{d: bus.ch_out, l: bus.ch_last, c: cyc});
            if (bus.sym_valid && bus.sym_ready)
                acc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] n, input logic l);
        bus.sym_in    = s;
        bus.noise_in  = n;
        bus.sym_last  = l;
        bus.sym_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.sym_ready) break;
        end
        tick();
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
        bus.noise_in  = 16'h5A5A;  // must never be picked up
    endtask

    task automatic get_out(input string tag, input logic [15:0] ed, input logic el,
                           output int oc);
        out_t o;
        oc = -1;
        for (int i = 0; i < 20 && out_q.size() == 0; i++) tick();
        chk({tag, "_present"}, 64'(out_q.size() > 0), 64'd1);
        if (out_q.size() > 0) begin
            o  = out_q.pop_front();
            oc = o.c;
            chk({tag, "_data"}, 64'(o.d), 64'(ed));
            chk({tag, "_last"}, 64'(o.l), 64'(el));
        end
    endtask

    task automatic wr_scale(input logic [15:0] v);
        bus.scale_in = v;
        bus.scale_wr = 1'b1;
        tick();
        bus.scale_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int oc;
        int idx;
        int acc_low;

        bus.noise_in  = '0;
        bus.sym_in    = '0;
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
        bus.scale_in  = '0;
        bus.scale_wr  = 1'b0;
        bus.ch_ready  = 1'b1;
        bus.stats_clr = 1'b0;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // reset state
        chk("rst_valid", 64'(bus.ch_valid), 64'd0);
        chk("rst_last",  64'(bus.ch_last),  64'd0);
        chk("rst_out",   64'(bus.ch_out),   64'd0);
        chk("rst_sat",   64'(bus.sat_count), 64'd0);
        chk("rst_ready", 64'(bus.sym_ready), 64'd1);
        chk("rst_nsum",  64'(bus.noise_sum), 64'd0);
        chk("rst_nsq",   64'(bus.noise_sq_sum), 64'd0);
        chk("rst_n",     64'(bus.stats_n), 64'd0);

        // basic add at unity scale, 3-cycle latency
        out_q.delete();
        acc_q.delete();
        send(16'h1000, 16'h0100, 1'b0);
        get_out("basic", 16'h1100, 1'b0, oc);
        chk("basic_lat", 64'(oc - (acc_q.size() > 0 ? acc_q[0] : -100)), 64'd3);
        chk("basic_sat", 64'(bus.sat_count), 64'd0);

        // saturation both rails, then exact max without clamping
        send(16'h7F00, 16'h0200, 1'b0);
        send(16'h8100, 16'hFE00, 1'b0);
        get_out("sat_hi", 16'h7FFF, 1'b0, oc);
        get_out("sat_lo", 16'h8000, 1'b0, oc);
        chk("sat_cnt2", 64'(bus.sat_count), 64'd2);
        send(16'h7F00, 16'h00FF, 1'b0);
        get_out("sat_edge", 16'h7FFF, 1'b0, oc);
        chk("sat_cnt_keep", 64'(bus.sat_count), 64'd2);

        // scale 0.5 takes effect only after the frame-last accept
        wr_scale(16'h4000);
        send(16'h0000, 16'hFF00, 1'b0);
        get_out("scl_pre", 16'hFF00, 1'b0, oc);
        send(16'h0010, 16'h0100, 1'b1);
        get_out("scl_lastsym", 16'h0110, 1'b1, oc);
        send(16'h0000, 16'hFF00, 1'b0);
        get_out("scl_half", 16'hFF80, 1'b0, oc);
        send(16'h0005, 16'hFFFF, 1'b0);          // -1*0.5 floors to -1
        get_out("scl_floor", 16'h0004, 1'b0, oc);

        // pending write to 0.25 waits for the next last
        wr_scale(16'h2000);
        send(16'h0000, 16'h0100, 1'b1);
        get_out("pend_old", 16'h0080, 1'b1, oc);
        send(16'h0000, 16'h0100, 1'b0);
        get_out("pend_new", 16'h0040, 1'b0, oc);

        // scale_wr coincident with last accept: zero scale transferred
        bus.scale_in = 16'h0000;
        bus.scale_wr = 1'b1;
        send(16'h0000, 16'h0100, 1'b1);
        bus.scale_wr = 1'b0;
        get_out("coinc_last", 16'h0040, 1'b1, oc);
        send(16'h1234, 16'h7FFF, 1'b0);
        get_out("zero_scale", 16'h1234, 1'b0, oc);
        send(16'h8000, 16'h8000, 1'b0);
        get_out("zero_min", 16'h8000, 1'b0, oc);

        // backpressure: ch_ready low 5 cycles, symbols continuous (scale 0)
        out_q.delete();
        idx = 0;
        acc_low = 0;
        bus.ch_ready = 1'b0;
        bus.noise_in = 16'h7FFF;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            if (c == 5) bus.ch_ready = 1'b1;
            bus.sym_valid = 1'b1;
            bus.sym_in    = 16'(16'h0200 + idx);
            bus.sym_last  = ((idx % 4) == 3);
            @(negedge clock);
            if (c == 3) begin
                chk("bp_ready_low", 64'(bus.sym_ready), 64'd0);
                chk("bp_hold_vld",  64'(bus.ch_valid),  64'd1);
                chk("bp_hold_d0",   64'(bus.ch_out),    64'h0200);
            end
            if (c == 4) chk("bp_hold_d1", 64'(bus.ch_out), 64'h0200);
            if (bus.sym_ready) begin
                if (!bus.ch_ready) acc_low++;
                idx++;
            end
            tick();
        end
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
        chk("bp_acc_low", 64'(acc_low), 64'd3);
        for (int i = 0; i < 10; i++)
            get_out($sformatf("bp%0d", i), 16'(16'h0200 + i), ((i % 4) == 3), oc);
        repeat (5) tick();
        chk("bp_extra", 64'(out_q.size()), 64'd0);

        // reset mid-stream with active scale 0.5 and 3 symbols in flight
        wr_scale(16'h4000);
        send(16'h0000, 16'h0000, 1'b1);
        get_out("pre_rst", 16'h0000, 1'b1, oc);
        out_q.delete();
        bus.ch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.sym_valid = 1'b1;
            bus.sym_in    = 16'(16'h0111 * (i + 1));
            bus.noise_in  = 16'h0100;
            tick();
        end
        bus.sym_valid = 1'b0;
        chk("mid_full", 64'(bus.ch_valid), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_vld",   64'(bus.ch_valid),  64'd0);
        chk("mid_rst_sat",   64'(bus.sat_count), 64'd0);
        chk("mid_rst_ready", 64'(bus.sym_ready), 64'd1);
        reset = 1'b0;
        bus.ch_ready = 1'b1;
        repeat (6) tick();
        chk("mid_stale", 64'(out_q.size()), 64'd0);
        send(16'h0000, 16'h0100, 1'b0);          // unity scale again
        get_out("mid_scale1", 16'h0100, 1'b0, oc);

        // statistics
        bus.stats_clr = 1'b1;
        tick();
        bus.stats_clr = 1'b0;
        send(16'h0000, 16'h0003, 1'b0);
        send(16'h0000, 16'hFFFB, 1'b0);
        send(16'h0000, 16'h0002, 1'b0);
        get_out("st0", 16'h0003, 1'b0, oc);
        get_out("st1", 16'hFFFB, 1'b0, oc);
        get_out("st2", 16'h0002, 1'b0, oc);
`ifdef AWGN_STATS_EN
        chk("st_sum", 64'(bus.noise_sum),    64'd0);
        chk("st_sq",  64'(bus.noise_sq_sum), 64'd38);
        chk("st_n",   64'(bus.stats_n),      64'd3);
        send(16'h0000, 16'h0007, 1'b0);
        get_out("st3", 16'h0007, 1'b0, oc);
        chk("st_sum4", 64'(bus.noise_sum),   64'd7);
`else
        chk("st_sum", 64'(bus.noise_sum),    64'd0);
        chk("st_sq",  64'(bus.noise_sq_sum), 64'd0);
        chk("st_n",   64'(bus.stats_n),      64'd0);
`endif
        bus.stats_clr = 1'b1;
        tick();
        bus.stats_clr = 1'b0;
        chk("clr_sum", 64'(bus.noise_sum),    64'd0);
        chk("clr_sq",  64'(bus.noise_sq_sum), 64'd0);
        chk("clr_n",   64'(bus.stats_n),      64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/awgn_channel.md
# awgn_channel

Downstream consumer of the `AWGN` generator's `awgn_out`. The block adds scaled Gaussian noise to a stream of signed baseband symbols, modelling an AWGN channel in front of the receiver. It runs a 3-stage valid/ready pipeline with a frame-synchronous noise-scale register and saturating output arithmetic. Its output feeds the demodulator under test.

## Interface
- `DATA_W`, 16, symbol and output width (signed two's complement)
- `NOISE_W`, 16, width of `noise_in` (signed, same LSB weight as symbols)
- `SCALE_W`, 16, noise scale width (unsigned Q1.15)
- `SATCNT_W`, 16, saturation counter width

- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `noise_in` in NOISE_W: free-running sample from `AWGN.awgn_out`, one new value per clock
- `sym_in` in DATA_W: input symbol
- `sym_valid` in 1: `sym_in` is valid
- `sym_last` in 1: last symbol of a frame
- `sym_ready` out 1: block accepts the symbol this cycle
- `scale_in` in SCALE_W: new noise scale
- `scale_wr` in 1: write `scale_in` to the shadow register
- `ch_out` out DATA_W: noisy symbol
- `ch_valid` out 1: `ch_out` is valid
- `ch_last` out 1: `sym_last`, delayed with its symbol
- `ch_ready` in 1: downstream accepts
- `sat_count` out SATCNT_W: number of saturated outputs; sticks at all-ones
- `stats_clr` in 1: clear the statistics (see Configuration)
- `noise_sum` out 32: signed sum of the scaled noise
- `noise_sq_sum` out 48: unsigned sum of the squared scaled noise
- `stats_n` out 32: number of samples accumulated

## Operation
- **Accept.** A symbol is accepted when `sym_valid && sym_ready`. The `noise_in` value present in that same cycle is captured with it. Noise in cycles without an accept is discarded.
- **S1 (capture).** Register `sym`, `noise` and `last`.
- **S2 (scale).** Multiply signed `noise` by unsigned `active_scale`, giving a 33-bit signed product. Arithmetic shift right by 15 (truncation toward −inf), giving an 18-bit signed `scaled_noise`.
- **S3 (add).** Sign-extend `sym` and `scaled_noise` to 19 bits and add them. Clamp the result to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and register it to `ch_out`.
  - When clamping occurs and `sat_count` is not all-ones, `sat_count` increments as the stage loads.
- **Pipeline control.**
  - Each stage holds a valid bit.
  - A stage loads when it is empty or when its contents move on in the same cycle.
  - `sym_ready = !s1_valid || s1_moves`. This is combinational from `ch_ready`; there is no skid buffer.
- **Scale update.**
  - `scale_wr` writes `shadow_scale` and sets `scale_pending`.
  - `active_scale <= shadow_scale` and `pending` clears on the cycle a symbol with `sym_last=1` is accepted. That symbol keeps the old scale; the next accepted symbol uses the new one.
  - If `scale_wr` and a `sym_last` accept occur in the same cycle, the newly written value is transferred.
  - When no update is pending, writes to the shadow register do not affect `active_scale`.
- **Zero scale.** `scale = 0` yields `ch_out == sym` exactly; no special-casing is needed.

## Timing
- Reset values:
  - `ch_valid=0`, `ch_last=0`, `ch_out=0`, `sat_count=0`.
  - All stage valids 0.
  - `sym_ready=1` in the first cycle after reset.
  - `shadow_scale = active_scale = 0x8000` (1.0), `scale_pending=0`.
  - Statistics outputs 0.
- Latency: a symbol accepted in cycle N presents `ch_valid` in cycle N+3 if `ch_ready` stays high.
- Throughput: 1 symbol per clock with `ch_ready` held high.
- Backpressure:
  - With `ch_ready` low, the pipeline fills to 3 entries, then `sym_ready` drops.
  - `ch_out`, `ch_valid` and `ch_last` hold stable until accepted.
  - No loss and no duplication.
- Reset asserted mid-operation flushes all stages in the next cycle. In-flight symbols are dropped.

## Configuration
- `AWGN_STATS_EN` defined:
  - On each S3 load: `noise_sum += scaled_noise` (sign-extended, wraps), `noise_sq_sum += scaled_noise²` (wraps), `stats_n += 1`.
  - `stats_clr` zeroes all three synchronously; on a simultaneous load, clear wins.
- `AWGN_STATS_EN` undefined:
  - The ports remain, tied to 0.
  - `stats_clr` is ignored.
  - No accumulator logic is present.

## Structure
- `awgn_pkg` holds:
  - default width constants
  - `SCALE_ONE = 16'h8000`
  - `SCALE_SHIFT = 15`
  - a saturate function for (W+3)→W
- One sub-module, `awgn_noise_scale`: the S2 registered multiply-shift stage, with its valid passthrough and a load enable.

## Test plan
- **Basic add.** `sym=0x1000`, `noise=0x0100`, scale reset value → `ch_out=0x1100` exactly 3 cycles after accept; `sat_count=0`.
- **Scaling.** `scale_wr` 0x4000, then a `sym_last` accept; next symbol `0x0000` with `noise=0xFF00` → `ch_out=0xFF80`.
  - A symbol sent before the `last` accept still gets full-scale noise.
- **Saturation.**
  - `sym=0x7F00`, `noise=0x0200` → `ch_out=0x7FFF`.
  - `sym=0x8100`, `noise=0xFE00` → `ch_out=0x8000`.
  - `sat_count=2`.
- **Backpressure.** Continuous `sym_valid` with incrementing symbols; `ch_ready` low for 5 cycles → `sym_ready` low after 3 accepts; the output sequence is gap-free with no repeats; `ch_last` is aligned.
- **Reset mid-stream.** Assert `reset` with 3 symbols in flight → next cycle `ch_valid=0`, `active_scale=0x8000`, `sat_count=0`; no stale output after release.
- **Statistics (`AWGN_STATS_EN`).** Scaled noise values +3, −5, +2 → `noise_sum=0`, `noise_sq_sum=38`, `stats_n=3`; `stats_clr` → all 0.
